// File: rtl/seq_deserializer_if.sv
// Bus bundle for seq_deserializer: two serial input lanes with shared framing,
// plus the parallel word-pair valid/ready output and status flags.
interface seq_deserializer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             bit_valid;
  logic             in_bit1;
  logic             in_bit2;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic [1:0]       parity_err;

  modport slave (
    input  start, bit_valid, in_bit1, in_bit2, out_ready,
    output out1, out2, out_valid, busy, overrun, parity_err
  );

  modport master (
    output start, bit_valid, in_bit1, in_bit2, out_ready,
    input  out1, out2, out_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/seq_deserializer.sv
// Dual-lane serial-to-parallel receiver with valid/ready word-pair output.
// Optional per-lane even-parity bit enabled by defining SEQ_DESER_PARITY_EN.
module seq_deserializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  seq_deserializer_if.slave bus
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] out1_q, out1_d, out2_q, out2_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] sh1_nx, sh2_nx;
`ifdef SEQ_DESER_PARITY_EN
  localparam logic [CNT_W-1:0] PARITY_POS = CNT_W'(WIDTH);
  logic [1:0]       perr_q, perr_d;
`endif

  // Shift registers with the current lane bits folded in at the entry end.
  always_comb begin
    if (MSB_FIRST) begin
      sh1_nx = {sh1_q[WIDTH-2:0], bus.in_bit1};
      sh2_nx = {sh2_q[WIDTH-2:0], bus.in_bit2};
    end else begin
      sh1_nx = {bus.in_bit1, sh1_q[WIDTH-1:1]};
      sh2_nx = {bus.in_bit2, sh2_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold default before the case so no path leaves
    // a combinational output unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    overrun_d = overrun_q;
`ifdef SEQ_DESER_PARITY_EN
    perr_d    = perr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          cnt_d     = '0;
          sh1_d     = '0;
          sh2_d     = '0;
          overrun_d = 1'b0;
        end
      end

      SHIFT: begin
        if (bus.start) begin
          // Restart wins over any bit presented in the same cycle.
          cnt_d     = '0;
          sh1_d     = '0;
          sh2_d     = '0;
          overrun_d = 1'b0;
        end else if (bus.bit_valid) begin
`ifdef SEQ_DESER_PARITY_EN
          if (cnt_q == PARITY_POS) begin
            state_d = HOLD;
            cnt_d   = '0;
            out1_d  = sh1_q;
            out2_d  = sh2_q;
            perr_d  = {(^sh2_q) ^ bus.in_bit2, (^sh1_q) ^ bus.in_bit1};
          end else begin
            sh1_d = sh1_nx;
            sh2_d = sh2_nx;
            cnt_d = cnt_q + CNT_ONE;
          end
`else
          sh1_d = sh1_nx;
          sh2_d = sh2_nx;
          if (cnt_q == LAST_DATA) begin
            state_d = HOLD;
            cnt_d   = '0;
            out1_d  = sh1_nx;
            out2_d  = sh2_nx;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`endif
        end
      end

      HOLD: begin
        if (bus.bit_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.out_ready) begin
          if (bus.start) begin
            state_d   = SHIFT;
            cnt_d     = '0;
            sh1_d     = '0;
            sh2_d     = '0;
            overrun_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh1_q     <= '0;
      sh2_q     <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SEQ_DESER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 2'b00;
    end else begin
      perr_q <= perr_d;
    end
  end
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 2'b00;
`endif

  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seq_deserializer.sv
// Bench for seq_deserializer: an MSB-first and an LSB-first instance share one
// serial stimulus; expectations come from a bit-placement model of the framing rules.
module tb_seq_deserializer;

  localparam int W       = 32;
  localparam int MAX_CYC = 20000;

  logic clk = 1'b0;
  logic reset;
  logic s_start, s_bv, s_b1, s_b2, s_rdy;
  int   total = 0;
  int   bad   = 0;

  seq_deserializer_if #(.WIDTH(W)) bus_m ();
  seq_deserializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.start     = s_start;
  assign bus_m.bit_valid = s_bv;
  assign bus_m.in_bit1   = s_b1;
  assign bus_m.in_bit2   = s_b2;
  assign bus_m.out_ready = s_rdy;
  assign bus_l.start     = s_start;
  assign bus_l.bit_valid = s_bv;
  assign bus_l.in_bit1   = s_b1;
  assign bus_l.in_bit2   = s_b2;
  assign bus_l.out_ready = s_rdy;

  seq_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(bus_m));
  seq_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(bus_l));

  always #5 clk = ~clk;

  initial begin
    #(MAX_CYC * 10);
    $display("FAIL watchdog: sim time %0t exceeded budget of %0d cycles", $time, MAX_CYC);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Stream bit i (the i-th bit sent) lands at W-1-i when MSB-first, at i when LSB-first.
  function automatic logic [W-1:0] land(input logic [W-1:0] st, input bit msb);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) r[W-1-i] = st[i];
      else     r[i]     = st[i];
    end
    return r;
  endfunction

  function automatic logic [4*W-1:0] exp_words(input logic [W-1:0] st1, input logic [W-1:0] st2);
    return {land(st1, 1'b1), land(st2, 1'b1), land(st1, 1'b0), land(st2, 1'b0)};
  endfunction

  function automatic logic [3:0] exp_perr(input logic [W-1:0] st1, input logic [W-1:0] st2,
                                          input logic p1, input logic p2);
`ifdef SEQ_DESER_PARITY_EN
    return {2{(^st2) ^ p2, (^st1) ^ p1}};
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [4*W-1:0] obs_words();
    return {bus_m.out1, bus_m.out2, bus_l.out1, bus_l.out2};
  endfunction

  // {valid_l, valid_m, busy_l, busy_m, overrun_l, overrun_m}
  function automatic logic [5:0] obs_flags();
    return {bus_l.out_valid, bus_m.out_valid, bus_l.busy, bus_m.busy, bus_l.overrun, bus_m.overrun};
  endfunction

  function automatic logic [3:0] obs_perr();
    return {bus_m.parity_err, bus_l.parity_err};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    s_start = 1'b1;
    s_bv    = 1'b0;
    tick();
    s_start = 1'b0;
  endtask

  // Sends one frame body (data bits, then parity bit when enabled) with
  // gap_lo..gap_hi stall cycles between bits; returns flags seen during the last bit.
  task automatic send_bits(input logic [W-1:0] st1, input logic [W-1:0] st2,
                           input logic p1, input logic p2, input int gap_lo, input int gap_hi,
                           output logic [1:0] pre_v, output logic [1:0] pre_busy);
    int nb;
    nb = W;
`ifdef SEQ_DESER_PARITY_EN
    nb = W + 1;
`endif
    pre_v    = 2'bxx;
    pre_busy = 2'bxx;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(gap_hi, gap_lo)) begin
          s_bv = 1'b0;
          s_b1 = 1'($urandom);
          s_b2 = 1'($urandom);
          tick();
        end
      end
      s_bv = 1'b1;
      s_b1 = (i < W) ? st1[i] : p1;
      s_b2 = (i < W) ? st2[i] : p2;
      if (i == nb - 1) begin
        pre_v    = {bus_l.out_valid, bus_m.out_valid};
        pre_busy = {bus_l.busy, bus_m.busy};
      end
      tick();
    end
    s_bv = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] st1, st2;
    logic [1:0]   pv, pb;
    $display("test_reset");
    reset = 1'b0; s_start = 1'b0; s_bv = 1'b0; s_b1 = 1'b0; s_b2 = 1'b0; s_rdy = 1'b0;
    #12;
    total++;
    if ({obs_words(), obs_flags(), obs_perr()} !== '0)
      begin bad++; $display("FAIL reset_state: words=%h flags=%b perr=%b want all zero", obs_words(), obs_flags(), obs_perr()); end
    reset = 1'b1;
    tick();
    // bit_valid in IDLE must not start anything
    s_bv = 1'b1; s_b1 = 1'b1; s_b2 = 1'b1;
    tick(); tick();
    s_bv = 1'b0;
    total++;
    if (obs_flags() !== 6'b0)
      begin bad++; $display("FAIL idle_ignores_bits: flags=%b want 000000", obs_flags()); end

    // complete a frame so the output registers hold something nonzero
    s_rdy = 1'b1;
    st1 = $urandom | 32'h1; st2 = $urandom | 32'h1;
    pulse_start();
    send_bits(st1, st2, ^st1, ^st2, 0, 0, pv, pb);
    tick();
    total++;
    if (obs_words() !== exp_words(st1, st2))
      begin bad++; $display("FAIL pre_reset_frame: got %h want %h", obs_words(), exp_words(st1, st2)); end

    pulse_start();
    for (int i = 0; i < 10; i++) begin
      s_bv = 1'b1; s_b1 = 1'($urandom); s_b2 = 1'($urandom);
      tick();
    end
    s_bv = 1'b0;
    total++;
    if (obs_flags() !== 6'b001100)
      begin bad++; $display("FAIL mid_frame_busy: flags=%b want 001100", obs_flags()); end
    reset = 1'b0;
    #2;
    total++;
    if ({obs_words(), obs_flags(), obs_perr()} !== '0)
      begin bad++; $display("FAIL async_reset: words=%h flags=%b want all zero", obs_words(), obs_flags()); end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    total++;
    if (obs_flags() !== 6'b0)
      begin bad++; $display("FAIL post_reset_idle: flags=%b want 000000", obs_flags()); end

    st1 = $urandom; st2 = $urandom;
    pulse_start();
    send_bits(st1, st2, ^st1, ^st2, 0, 1, pv, pb);
    total++;
    if ({obs_words(), obs_flags()} !== {exp_words(st1, st2), 6'b110000})
      begin bad++; $display("FAIL post_reset_frame: got %h/%b want %h/110000", obs_words(), obs_flags(), exp_words(st1, st2)); end
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] st1, st2, keep1;
    logic [1:0]   pv, pb;
    $display("test_basic");
    s_rdy = 1'b1;
    // land(x,1) reverses bit order, so this stream gives DEADBEEF on the MSB-first instance
    st1 = land(32'hDEADBEEF, 1'b1);
    st2 = land(32'h00000001, 1'b1);
    pulse_start();
    send_bits(st1, st2, ^st1, ^st2, 0, 0, pv, pb);
    total++;
    if ({pv, pb} !== 4'b0011)
      begin bad++; $display("FAIL basic_latency: valid/busy during last bit=%b/%b want 00/11", pv, pb); end
    total++;
    if ({bus_m.out1, bus_m.out2} !== {32'hDEADBEEF, 32'h00000001})
      begin bad++; $display("FAIL basic_msb_words: got %h %h want deadbeef 00000001", bus_m.out1, bus_m.out2); end
    total++;
    if ({obs_words(), obs_flags(), obs_perr()} !== {exp_words(st1, st2), 6'b110000, exp_perr(st1, st2, ^st1, ^st2)})
      begin bad++; $display("FAIL basic_frame: got %h/%b/%b", obs_words(), obs_flags(), obs_perr()); end
    keep1 = bus_m.out1;
    tick();
    total++;
    if ({obs_flags(), bus_m.out1} !== {6'b000000, keep1})
      begin bad++; $display("FAIL basic_one_cycle_valid: flags=%b out1=%h want 000000 %h", obs_flags(), bus_m.out1, keep1); end
  endtask

  task automatic test_stall_lsb();
    logic [W-1:0] st1, st2;
    logic [1:0]   pv, pb;
    $display("test_stall_lsb");
    s_rdy = 1'b1;
    st1 = 32'hDEADBEEF;
    st2 = 32'h00000001;
    pulse_start();
    send_bits(st1, st2, ^st1, ^st2, 1, 1, pv, pb);
    total++;
    if ({pv, pb} !== 4'b0011)
      begin bad++; $display("FAIL stall_latency: valid/busy during last bit=%b/%b want 00/11", pv, pb); end
    total++;
    if ({bus_l.out1, bus_l.out2} !== {32'hDEADBEEF, 32'h00000001})
      begin bad++; $display("FAIL stall_lsb_words: got %h %h want deadbeef 00000001", bus_l.out1, bus_l.out2); end
    total++;
    if ({obs_words(), obs_flags()} !== {exp_words(st1, st2), 6'b110000})
      begin bad++; $display("FAIL stall_frame: got %h/%b want %h/110000", obs_words(), obs_flags(), exp_words(st1, st2)); end
    tick();
  endtask

  task automatic test_overrun();
    logic [W-1:0] st1, st2;
    logic [1:0]   pv, pb;
    $display("test_overrun");
    s_rdy = 1'b0;
    st1 = $urandom; st2 = $urandom;
    pulse_start();
    send_bits(st1, st2, ^st1, ^st2, 0, 0, pv, pb);
    for (int k = 0; k < 5; k++) begin
      s_bv    = (k < 2);
      s_b1    = 1'($urandom);
      s_b2    = 1'($urandom);
      s_start = (k == 3);
      tick();
      total++;
      if ({obs_words(), obs_flags()} !== {exp_words(st1, st2), 6'b110011})
        begin bad++; $display("FAIL hold_stable_%0d: got %h/%b want %h/110011", k, obs_words(), obs_flags(), exp_words(st1, st2)); end
    end
    s_bv = 1'b0;
    s_rdy = 1'b1; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    total++;
    if (obs_flags() !== 6'b001100)
      begin bad++; $display("FAIL b2b_restart: flags=%b want 001100", obs_flags()); end
    st1 = $urandom; st2 = $urandom;
    send_bits(st1, st2, ^st1, ^st2, 0, 0, pv, pb);
    total++;
    if ({obs_words(), obs_flags()} !== {exp_words(st1, st2), 6'b110000})
      begin bad++; $display("FAIL after_overrun_frame: got %h/%b want %h/110000", obs_words(), obs_flags(), exp_words(st1, st2)); end
    tick();
  endtask

  task automatic test_abort();
    logic [W-1:0] st;
    logic [1:0]   pv, pb;
    $display("test_abort");
    s_rdy = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      s_bv = 1'b1; s_b1 = 1'($urandom); s_b2 = 1'($urandom);
      tick();
    end
    // restart with a valid bit in the same cycle; that bit must be discarded
    s_start = 1'b1; s_bv = 1'b1; s_b1 = 1'b1; s_b2 = 1'b1;
    tick();
    s_start = 1'b0; s_bv = 1'b0;
    st = 32'hA5A5A5A5;
    send_bits(st, st, ^st, ^st, 0, 0, pv, pb);
    total++;
    if ({pv, pb} !== 4'b0011)
      begin bad++; $display("FAIL abort_latency: valid/busy during last bit=%b/%b want 00/11", pv, pb); end
    total++;
    if ({obs_words(), obs_flags()} !== {{4{32'hA5A5A5A5}}, 6'b110000})
      begin bad++; $display("FAIL abort_frame: got %h/%b want a5a5a5a5 x4/110000", obs_words(), obs_flags()); end
    tick();
  endtask

`ifdef SEQ_DESER_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] st1, st2;
    logic [1:0]   pv, pb;
    $display("test_parity");
    s_rdy = 1'b1;
    st1 = land(32'h00000001, 1'b1);
    st2 = land(32'h00000003, 1'b1);
    pulse_start();
    send_bits(st1, st2, 1'b1, 1'b1, 0, 0, pv, pb);
    total++;
    if ({pv, pb} !== 4'b0011)
      begin bad++; $display("FAIL parity_latency: valid/busy during 33rd bit=%b/%b want 00/11", pv, pb); end
    total++;
    if ({bus_m.parity_err, bus_m.out1, bus_m.out2} !== {2'b10, 32'h00000001, 32'h00000003})
      begin bad++; $display("FAIL parity_vector: perr=%b out=%h %h want 10 00000001 00000003", bus_m.parity_err, bus_m.out1, bus_m.out2); end
    total++;
    if (bus_l.parity_err !== 2'b10)
      begin bad++; $display("FAIL parity_lsb: perr=%b want 10", bus_l.parity_err); end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] st1, st2;
    logic         p1, p2, exp_ovr;
    logic [1:0]   pv, pb;
    int           hold;
    $display("test_back_to_back");
    s_rdy = 1'b0;
    pulse_start();
    for (int f = 0; f < 16; f++) begin
      st1 = $urandom; st2 = $urandom;
      p1 = (^st1) ^ ($urandom_range(3, 0) == 0);
      p2 = (^st2) ^ ($urandom_range(3, 0) == 0);
      s_rdy = 1'b0;
      send_bits(st1, st2, p1, p2, 0, 2, pv, pb);
      total++;
      if ({pv, pb} !== 4'b0011)
        begin bad++; $display("FAIL b2b_latency_%0d: valid/busy=%b/%b want 00/11", f, pv, pb); end
      hold = $urandom_range(3, 0);
      exp_ovr = 1'b0;
      for (int k = 0; k < hold; k++) begin
        s_bv = 1'($urandom);
        s_b1 = 1'($urandom);
        s_b2 = 1'($urandom);
        exp_ovr = exp_ovr | s_bv;
        tick();
      end
      s_bv = 1'b0;
      total++;
      if ({obs_words(), obs_flags(), obs_perr()} !== {exp_words(st1, st2), 4'b1100, {2{exp_ovr}}, exp_perr(st1, st2, p1, p2)})
        begin bad++; $display("FAIL b2b_frame_%0d: got %h/%b/%b want %h ovr=%b perr=%b", f, obs_words(), obs_flags(), obs_perr(), exp_words(st1, st2), exp_ovr, exp_perr(st1, st2, p1, p2)); end
      s_rdy = 1'b1;
      s_start = (f < 15);
      tick();
      s_start = 1'b0;
      total++;
      if (obs_flags() !== ((f < 15) ? 6'b001100 : {4'b0000, {2{exp_ovr}}}))
        begin bad++; $display("FAIL b2b_handoff_%0d: flags=%b", f, obs_flags()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_lsb();
    test_overrun();
    test_abort();
`ifdef SEQ_DESER_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
